// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, drives a 1-cycle ROM, queues tagged words for decode.
// Optional FETCH_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_queue #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 49,
    parameter int DEPTH   = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               dec_ready,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [CW-1:0]      count
);

    logic [ADDR_W-1:0]  r_pc;
    logic               r_req_v;
    logic [ADDR_W-1:0]  r_req_pc;
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic [CW:0]        w_occ;
    logic               w_issue;
    logic               w_fifo_v;
    logic               w_byp;
    logic               w_push;
    logic               w_pop;

    // Credit counts the in-flight word but not a same-cycle pop.
    assign w_occ    = {1'b0, r_count} + (CW+1)'(r_req_v);
    assign w_issue  = !reset && !redirect && (w_occ < (CW+1)'(DEPTH));
    assign w_fifo_v = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    assign w_byp = !reset && !redirect && !w_fifo_v && r_req_v;
`else
    assign w_byp = 1'b0;
`endif

    assign w_pop  = w_fifo_v && dec_ready && !redirect && !reset;
    assign w_push = r_req_v && !redirect && !reset
                    && !(w_byp && dec_ready);

    assign rom_en    = w_issue;
    assign rom_addr  = r_pc;
    assign dec_valid = w_fifo_v || w_byp;
    assign count     = r_count;

    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        if (w_fifo_v) begin
            dec_instr = r_mem_instr[r_rptr];
            dec_pc    = r_mem_pc[r_rptr];
        end else if (w_byp) begin
            dec_instr = rom_data;
            dec_pc    = r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_req_v  <= 1'b0;
        end else begin
            r_req_v <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + ADDR_W'(1);
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= rom_data;
            r_mem_pc[r_wptr]    <= r_req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue.
// ROM returns a word tagged with its address.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int L      = 1;
  localparam int CNT_SS = 0;
  localparam bit BYP    = 1'b1;
`else
  localparam int L      = 2;
  localparam int CNT_SS = 1;
  localparam bit BYP    = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [48:0] rom_data;
  logic        dec_ready;
  logic        dec_valid;
  logic [48:0] dec_instr;
  logic [5:0]  dec_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .rom_en(rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .dec_ready(dec_ready),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mk(
    input logic [5:0] a
  );
    return {1'b1, 42'd0, a};
  endfunction

  initial rom_data = '0;
  always @(posedge clk) begin
    if (rom_en) rom_data <= mk(rom_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input bit ok,
                     input string tag);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
    logic [5:0] e;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b1;

    cyc();
    cyc();
    chk(rom_en === 1'b0, "rst_en");
    chk(rom_addr === 6'd0, "rst_addr");
    chk(dec_valid === 1'b0, "rst_valid");
    chk(dec_instr === 49'd0, "rst_instr");
    chk(dec_pc === 6'd0, "rst_pc");
    chk(count === 3'd0, "rst_count");
    reset = 1'b0;
    #1;
    chk(rom_en === 1'b1, "c0_en");
    chk(rom_addr === 6'd0, "c0_addr");
    cyc();
    chk(rom_addr === 6'd1, "c1_addr");
    chk(dec_valid === BYP, "c1_valid");
    for (int k = 0; k < 4; k++) begin
      cyc();
      e = 6'(2 + k - L);
      chk(dec_valid === 1'b1, "s1_valid");
      chk(dec_pc === e, "s1_pc");
      chk(dec_instr === mk(e), "s1_instr");
      chk(count === 3'(CNT_SS), "s1_count");
      chk(rom_addr === 6'(2 + k), "s1_addr");
    end

    reset = 1'b1;
    dec_ready = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    repeat (5) cyc();
    chk(count === 3'd4, "s2_count");
    chk(rom_en === 1'b0, "s2_en");
    chk(rom_addr === 6'd4, "s2_addr");
    chk(dec_pc === 6'd0, "s2_pc0");
    cyc();
    dec_ready = 1'b1;
    #1;
    chk(rom_en === 1'b0, "s2_cons_en");
    chk(dec_pc === 6'd0, "s2_head");
    cyc();
    chk(count === 3'd3, "s2_c7_count");
    chk(dec_pc === 6'd1, "s2_c7_pc");
    chk(rom_en === 1'b1, "s2_c7_en");
    chk(rom_addr === 6'd4, "s2_c7_addr");
    cyc();
    chk(dec_pc === 6'd2, "s2_c8_pc");
    chk(count === 3'd2, "s2_c8_count");
    cyc();
    chk(dec_pc === 6'd3, "s2_c9_pc");
    cyc();
    chk(dec_pc === 6'd4, "s2_c10_pc");
    chk(count === 3'd2, "s2_c10_count");

    reset = 1'b1;
    dec_ready = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    repeat (4) cyc();
    chk(count === 3'd3, "s3_pre_count");
    redirect = 1'b1;
    redirect_pc = 6'h20;
    #1;
    chk(rom_en === 1'b0, "s3_rd_en");
    cyc();
    redirect = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk(count === 3'd0, "s3_count");
    chk(dec_valid === 1'b0, "s3_valid");
    chk(rom_addr === 6'h20, "s3_addr");
    chk(rom_en === 1'b1, "s3_en");
    cyc();
    chk(dec_valid === BYP, "s3_e1_valid");
    chk(dec_pc === (BYP ? 6'h20 : 6'h00),
        "s3_e1_pc");
    cyc();
    chk(dec_valid === 1'b1, "s3_e2_valid");
    chk(dec_pc === (BYP ? 6'h21 : 6'h20),
        "s3_e2_pc");
    chk(count === 3'(CNT_SS), "s3_e2_count");
    cyc();
    chk(dec_pc === (BYP ? 6'h22 : 6'h21),
        "s3_e3_pc");

    redirect = 1'b1;
    redirect_pc = 6'h3E;
    cyc();
    redirect = 1'b0;
    #1;
    chk(rom_addr === 6'h3E, "s4_addr");
    repeat (L) cyc();
    for (int k = 0; k < 4; k++) begin
      e = 6'(8'h3E + k);
      chk(dec_valid === 1'b1, "s4_valid");
      chk(dec_pc === e, "s4_pc");
      cyc();
    end

    reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 6'h10;
    cyc();
    reset = 1'b0;
    redirect = 1'b0;
    #1;
    chk(rom_addr === 6'd0, "s5_addr");
    chk(rom_en === 1'b1, "s5_en");
    chk(count === 3'd0, "s5_count");
    repeat (L) cyc();
    chk(dec_valid === 1'b1, "s5_valid");
    chk(dec_pc === 6'd0, "s5_pc");

    redirect = 1'b1;
    redirect_pc = 6'h30;
    cyc();
    redirect = 1'b0;
    #1;
    chk(count === 3'd0, "s5b_count");
    chk(dec_valid === 1'b0, "s5b_valid");
    chk(rom_addr === 6'h30, "s5b_addr");
    repeat (L) cyc();
    chk(dec_pc === 6'h30, "s5b_first");
    chk(dec_instr === mk(6'h30), "s5b_instr");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
